irq_priority_ctrl: RTL

- Sequential 8-source interrupt controller built around 8-to-3 priority encoding.
- Samples eight active-low request lines and applies a programmable mask.
- Arbitrates by fixed or round-robin priority and presents one encoded vector to a consumer through an irq/ack/eoi handshake.
- Sits between the external request sources and the downstream service logic, and sequences access to that single service resource.

---
 rtl/irq_priority_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: 8-source active-low interrupt controller with mask, fixed or
// round-robin arbitration, and an irq/ack/eoi handshake with spurious/timeout exits.
`default_nettype none

module irq_priority_ctrl #(
  parameter int RR_EN       = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req_n,
  input  logic       mask_wr,
  input  logic [7:0] mask_din,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic       busy,
  output logic       gs,
  output logic [7:0] mask,
  output logic       spur,
  output logic       tmo
);

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pend;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] last, last_nxt;
  logic [2:0] vec_nxt;
  logic       irq_nxt, busy_nxt, spur_nxt, tmo_nxt;
  logic [2:0] start, idx, win;
  logic       found;

  assign gs = |pend;

  // Descending search from start; fixed mode always starts at 7 so the
  // highest set index wins, round-robin starts just below the last grant.
  always_comb begin
    start = (RR_EN != 0) ? (last - 3'd1) : 3'd7;
    win   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = start - 3'(k);
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq;
    vec_nxt   = vec;
    busy_nxt  = busy;
    spur_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          vec_nxt   = win;
          irq_nxt   = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (ack) begin
          irq_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          last_nxt  = vec;
          state_nxt = SERVICE;
        end else if (!pend[vec]) begin
          irq_nxt   = 1'b0;
          spur_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          irq_nxt   = 1'b0;
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SERVICE: begin
        if (eoi) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        irq_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend  <= 8'h00;
      mask  <= 8'h00;
      cnt   <= 8'd0;
      last  <= 3'd0;
      irq   <= 1'b0;
      vec   <= 3'd0;
      busy  <= 1'b0;
      spur  <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      // pend sees the mask value from before any same-edge write
      pend  <= ~req_n & ~mask;
      if (mask_wr) mask <= mask_din;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      irq   <= irq_nxt;
      vec   <= vec_nxt;
      busy  <= busy_nxt;
      spur  <= spur_nxt;
      tmo   <= tmo_nxt;
    end
  end

endmodule

`default_nettype wire
